// File: rtl/alu_sequencer_pkg.sv
// Shared opcodes, flag bit positions, FSM encoding and opcode legality check.
package alu_sequencer_pkg;

  localparam logic [7:0] OP_ADD = 8'h01;
  localparam logic [7:0] OP_SUB = 8'h02;
  localparam logic [7:0] OP_RSV = 8'h0C;  // hole in the opcode space
  localparam logic [7:0] OP_ROR = 8'h13;

  localparam int unsigned FLG_Z = 0;
  localparam int unsigned FLG_C = 1;
  localparam int unsigned FLG_S = 2;
  localparam int unsigned FLG_P = 3;
  localparam int unsigned FLG_I = 4;
  localparam int unsigned FLG_D = 5;
  localparam int unsigned FLG_O = 6;

  localparam int unsigned CntW = 4;

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StWb
  } state_e;

  function automatic logic is_legal_op(input logic [7:0] op);
    return (op >= OP_ADD) && (op <= OP_ROR) && (op != OP_RSV);
  endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Bundle between the sequencer, its instruction source and the ALU.
interface alu_sequencer_if #(
  parameter int unsigned NREGS = 8
);
  localparam int unsigned AW = $clog2(NREGS);

  logic          instr_valid;
  logic          instr_ready;
  logic [7:0]    instr_op;
  logic [AW-1:0] instr_rd;
  logic [AW-1:0] instr_rs1;
  logic [AW-1:0] instr_rs2;
  logic          ld_en;
  logic [AW-1:0] ld_addr;
  logic [7:0]    ld_data;
  logic [AW-1:0] dbg_addr;
  logic [7:0]    dbg_data;
  logic [7:0]    operand1;
  logic [7:0]    operand2;
  logic [7:0]    ALU_sel;
  logic [7:0]    operation_result;
  logic [6:0]    Flags;
  logic [6:0]    flags_q;
  logic          done;
  logic          illegal_op;

  modport slave (
    input  instr_valid, instr_op, instr_rd, instr_rs1, instr_rs2,
    input  ld_en, ld_addr, ld_data, dbg_addr, operation_result, Flags,
    output instr_ready, dbg_data, operand1, operand2, ALU_sel, flags_q, done, illegal_op
  );

  modport master (
    output instr_valid, instr_op, instr_rd, instr_rs1, instr_rs2,
    output ld_en, ld_addr, ld_data, dbg_addr, operation_result, Flags,
    input  instr_ready, dbg_data, operand1, operand2, ALU_sel, flags_q, done, illegal_op
  );

endinterface

// File: rtl/alu_sequencer_regfile.sv
// NREGS x 8 register file: two operand read ports, a debug read port,
// a writeback port and an external load port (writeback wins on collision).
module alu_sequencer_regfile #(
  parameter int unsigned NRegs = 8,
  parameter int unsigned AddrW = $clog2(NRegs)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [AddrW-1:0] rd1_addr_i,
  output logic [7:0]       rd1_data_o,
  input  logic [AddrW-1:0] rd2_addr_i,
  output logic [7:0]       rd2_data_o,
  input  logic [AddrW-1:0] dbg_addr_i,
  output logic [7:0]       dbg_data_o,
  input  logic             wb_en_i,
  input  logic [AddrW-1:0] wb_addr_i,
  input  logic [7:0]       wb_data_i,
  input  logic             ld_en_i,
  input  logic [AddrW-1:0] ld_addr_i,
  input  logic [7:0]       ld_data_i
);

  logic [7:0] mem_q [NRegs];

  assign rd1_data_o = mem_q[rd1_addr_i];
  assign rd2_data_o = mem_q[rd2_addr_i];
  assign dbg_data_o = mem_q[dbg_addr_i];

  // Per-entry write: writeback has priority, a same-address load is dropped.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NRegs; i++) begin
      if (rst_i) begin
        mem_q[i] <= '0;
      end else if (wb_en_i && (wb_addr_i == AddrW'(i))) begin
        mem_q[i] <= wb_data_i;
      end else if (ld_en_i && (ld_addr_i == AddrW'(i))) begin
        mem_q[i] <= ld_data_i;
      end
    end
  end

endmodule

// File: rtl/alu_sequencer.sv
// Issue/writeback sequencer: reads operands, drives the ALU, waits SETTLE_CYCLES,
// then writes the result back and updates the architectural flags.
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned NREGS         = 8
) (
  input  logic            clk,
  input  logic            rst,
  alu_sequencer_if.slave  bus
);

  localparam int unsigned AW = $clog2(NREGS);

  state_e         state_q;
  logic [CntW-1:0] cnt_q;
  logic [7:0]     op1_q, op2_q, sel_q;
  logic [AW-1:0]  rd_q;
  logic [6:0]     flags_q, flags_d;
  logic           done_q, illegal_q;
  logic [7:0]     rs1_data, rs2_data;
  logic           wb_en;
  logic           unused_flags;

  assign wb_en        = (state_q == StWb);
  assign unused_flags = ^{bus.Flags[FLG_I], bus.Flags[FLG_P], bus.Flags[FLG_S], bus.Flags[FLG_Z]};

  alu_sequencer_regfile #(
    .NRegs (NREGS),
    .AddrW (AW)
  ) u_regfile (
    .clk_i      (clk),
    .rst_i      (rst),
    .rd1_addr_i (bus.instr_rs1),
    .rd1_data_o (rs1_data),
    .rd2_addr_i (bus.instr_rs2),
    .rd2_data_o (rs2_data),
    .dbg_addr_i (bus.dbg_addr),
    .dbg_data_o (bus.dbg_data),
    .wb_en_i    (wb_en),
    .wb_addr_i  (rd_q),
    .wb_data_i  (bus.operation_result),
    .ld_en_i    (bus.ld_en),
    .ld_addr_i  (bus.ld_addr),
    .ld_data_i  (bus.ld_data)
  );

  // Flags for writeback: Z/S/P derived from the result, C/D from the ALU, O recomputed for ADD/SUB.
  always_comb begin
    logic [7:0] res;
    res            = bus.operation_result;
    flags_d        = '0;
    flags_d[FLG_Z] = (res == 8'h00);
    flags_d[FLG_C] = bus.Flags[FLG_C];
    flags_d[FLG_S] = res[7];
    flags_d[FLG_P] = ~^res;
    flags_d[FLG_I] = 1'b0;
    flags_d[FLG_D] = bus.Flags[FLG_D];
    if (sel_q == OP_ADD) begin
      flags_d[FLG_O] = (op1_q[7] == op2_q[7]) && (res[7] != op1_q[7]);
    end else if (sel_q == OP_SUB) begin
      flags_d[FLG_O] = (op1_q[7] != op2_q[7]) && (res[7] != op1_q[7]);
    end else begin
      flags_d[FLG_O] = bus.Flags[FLG_O];
    end
  end

  // Sequencer FSM with registered ALU-facing and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      op1_q     <= '0;
      op2_q     <= '0;
      sel_q     <= '0;
      rd_q      <= '0;
      flags_q   <= '0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.instr_valid) begin
            if (is_legal_op(bus.instr_op)) begin
              op1_q   <= rs1_data;
              op2_q   <= rs2_data;
              sel_q   <= bus.instr_op;
              rd_q    <= bus.instr_rd;
              cnt_q   <= '0;
              state_q <= StSettle;
            end else begin
              illegal_q <= 1'b1;
            end
          end
        end
        StSettle: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CntW'(SETTLE_CYCLES - 1)) state_q <= StWb;
        end
        StWb: begin
          flags_q <= flags_d;
          done_q  <= 1'b1;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.instr_ready = (state_q == StIdle);
  assign bus.operand1    = op1_q;
  assign bus.operand2    = op2_q;
  assign bus.ALU_sel     = sel_q;
  assign bus.flags_q     = flags_q;
  assign bus.done        = done_q;
  assign bus.illegal_op  = illegal_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed plus random bench; the bench also plays the ALU.
module tb_alu_sequencer;

  localparam int unsigned S = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_sequencer_if #(.NREGS(8)) bus ();

  alu_sequencer #(
    .SETTLE_CYCLES (S),
    .NREGS         (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [7:0] mreg [8];
  logic [6:0] mflags;
  logic [6:0] junk;

  // Reference ALU: returns {carry, result}; non-ADD/SUB ops use an arbitrary mixing function.
  function automatic logic [8:0] alu_fn(input logic [7:0] op, input logic [7:0] a,
                                        input logic [7:0] b);
    logic [7:0] sw;
    sw = {b[3:0], b[7:4]};
    if (op == 8'h01) return {1'b0, a} + {1'b0, b};
    if (op == 8'h02) return {(a < b), 8'(a - b)};
    return {a[0] ^ b[7], 8'((a ^ sw) + op)};
  endfunction

  always_comb begin
    logic [8:0] cr;
    cr                   = alu_fn(bus.ALU_sel, bus.operand1, bus.operand2);
    bus.operation_result = cr[7:0];
    bus.Flags            = {junk[6:2], cr[8], junk[0]};
  end

  function automatic logic legal(input logic [7:0] op);
    return (op >= 8'h01 && op <= 8'h0B) || (op >= 8'h0D && op <= 8'h13);
  endfunction

  function automatic logic [6:0] exp_flags(input logic [7:0] op, input logic [7:0] a,
                                           input logic [7:0] b, input logic [7:0] r,
                                           input logic c, input logic [6:0] jf);
    logic [6:0] f;
    f[0] = (r == 0);
    f[1] = c;
    f[2] = r[7];
    f[3] = ~^r;
    f[4] = 1'b0;
    f[5] = jf[5];
    if (op == 8'h01)      f[6] = (a[7] == b[7]) && (r[7] != a[7]);
    else if (op == 8'h02) f[6] = (a[7] != b[7]) && (r[7] != a[7]);
    else                  f[6] = jf[6];
    return f;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_regs();
    for (int i = 0; i < 8; i++) begin
      bus.dbg_addr = 3'(i);
      #1;
      chk($sformatf("reg%0d", i), bus.dbg_data, mreg[i]);
    end
  endtask

  task automatic load(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.ld_en   = 1'b1;
    bus.ld_addr = a;
    bus.ld_data = d;
    @(negedge clk);
    bus.ld_en = 1'b0;
    mreg[a]   = d;
  endtask

  task automatic issue(input logic [7:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                       input logic [2:0] rs2, input logic ld_wb, input logic [2:0] ld_a,
                       input logic [7:0] ld_d);
    logic [7:0] a, b;
    logic [8:0] cr;
    int cyc;
    a = mreg[rs1];
    b = mreg[rs2];
    @(negedge clk);
    chk("ready_idle", 8'(bus.instr_ready), 8'd1);
    bus.instr_op    = op;
    bus.instr_rd    = rd;
    bus.instr_rs1   = rs1;
    bus.instr_rs2   = rs2;
    bus.instr_valid = 1'b1;
    @(negedge clk);
    bus.instr_valid = 1'b0;
    if (!legal(op)) begin
      chk("illegal_pulse", 8'(bus.illegal_op), 8'd1);
      chk("illegal_ready", 8'(bus.instr_ready), 8'd1);
      @(negedge clk);
      chk("illegal_clear", 8'(bus.illegal_op), 8'd0);
      chk("illegal_flags", 8'(bus.flags_q), 8'(mflags));
      check_regs();
      return;
    end
    chk("illegal_quiet", 8'(bus.illegal_op), 8'd0);
    chk("operand1", bus.operand1, a);
    chk("operand2", bus.operand2, b);
    chk("alu_sel", bus.ALU_sel, op);
    chk("busy", 8'(bus.instr_ready), 8'd0);
    cyc = 0;
    while (!bus.done && cyc < 40) begin
      if (ld_wb && cyc == int'(S)) begin
        bus.ld_en   = 1'b1;
        bus.ld_addr = ld_a;
        bus.ld_data = ld_d;
      end else begin
        bus.ld_en = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    bus.ld_en = 1'b0;
    chk("latency", 8'(cyc), 8'(S + 1));
    chk("ready_with_done", 8'(bus.instr_ready), 8'd1);
    cr = alu_fn(op, a, b);
    if (ld_wb) mreg[ld_a] = ld_d;
    mreg[rd] = cr[7:0];
    mflags   = exp_flags(op, a, b, cr[7:0], cr[8], junk);
    chk("flags", 8'(bus.flags_q), 8'(mflags));
    chk("sel_hold", bus.ALU_sel, op);
    check_regs();
    @(negedge clk);
    chk("done_pulse", 8'(bus.done), 8'd0);
  endtask

  initial begin
    bus.instr_valid = 1'b0;
    bus.instr_op    = '0;
    bus.instr_rd    = '0;
    bus.instr_rs1   = '0;
    bus.instr_rs2   = '0;
    bus.ld_en       = 1'b0;
    bus.ld_addr     = '0;
    bus.ld_data     = '0;
    bus.dbg_addr    = '0;
    junk            = '0;
    mflags          = '0;
    for (int i = 0; i < 8; i++) mreg[i] = '0;

    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_ready", 8'(bus.instr_ready), 8'd1);
    chk("rst_op1", bus.operand1, 8'h00);
    chk("rst_op2", bus.operand2, 8'h00);
    chk("rst_sel", bus.ALU_sel, 8'h00);
    chk("rst_flags", 8'(bus.flags_q), 8'h00);
    chk("rst_done", 8'(bus.done), 8'd0);
    chk("rst_illegal", 8'(bus.illegal_op), 8'd0);
    check_regs();

    // Directed: basic ADD, carry-out to zero, signed overflow on ADD and SUB.
    load(3'd1, 8'h05);
    load(3'd2, 8'h03);
    issue(8'h01, 3'd3, 3'd1, 3'd2, 1'b0, 3'd0, 8'h00);
    chk("t1_r3", mreg[3], 8'h08);
    chk("t1_flags", 8'(bus.flags_q), 8'h00);
    load(3'd1, 8'hFF);
    load(3'd2, 8'h01);
    issue(8'h01, 3'd3, 3'd1, 3'd2, 1'b0, 3'd0, 8'h00);
    chk("t2_flags", 8'(bus.flags_q), 8'h0B);
    load(3'd1, 8'h7F);
    issue(8'h01, 3'd3, 3'd1, 3'd2, 1'b0, 3'd0, 8'h00);
    chk("t3_add_flags", 8'(bus.flags_q), 8'h44);
    issue(8'h02, 3'd4, 3'd3, 3'd2, 1'b0, 3'd0, 8'h00);
    chk("t3_sub_r4", mreg[4], 8'h7F);
    chk("t3_sub_flags", 8'(bus.flags_q), 8'h40);

    // Illegal opcodes and writeback/load collisions.
    issue(8'h0C, 3'd5, 3'd1, 3'd2, 1'b0, 3'd0, 8'h00);
    issue(8'h00, 3'd5, 3'd1, 3'd2, 1'b0, 3'd0, 8'h00);
    issue(8'h14, 3'd5, 3'd1, 3'd2, 1'b0, 3'd0, 8'h00);
    issue(8'h01, 3'd3, 3'd1, 3'd2, 1'b1, 3'd3, 8'hA5);
    issue(8'h02, 3'd4, 3'd1, 3'd2, 1'b1, 3'd6, 8'h5A);

    // Random instructions with random ALU side flags and occasional WB-edge loads.
    for (int n = 0; n < 40; n++) begin
      junk = 7'($urandom);
      if ($urandom_range(0, 2) == 0) load(3'($urandom), 8'($urandom));
      issue(8'($urandom_range(0, 21)), 3'($urandom), 3'($urandom), 3'($urandom),
            1'($urandom), 3'($urandom), 8'($urandom));
    end

    // Reset mid-SETTLE aborts the instruction.
    load(3'd5, 8'h11);
    @(negedge clk);
    bus.instr_op    = 8'h01;
    bus.instr_rd    = 3'd6;
    bus.instr_rs1   = 3'd5;
    bus.instr_rs2   = 3'd5;
    bus.instr_valid = 1'b1;
    @(negedge clk);
    bus.instr_valid = 1'b0;
    rst             = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) mreg[i] = '0;
    chk("abort_done", 8'(bus.done), 8'd0);
    chk("abort_ready", 8'(bus.instr_ready), 8'd1);
    chk("abort_op1", bus.operand1, 8'h00);
    chk("abort_op2", bus.operand2, 8'h00);
    chk("abort_sel", bus.ALU_sel, 8'h00);
    chk("abort_flags", 8'(bus.flags_q), 8'h00);
    check_regs();
    @(negedge clk);
    chk("abort_no_done", 8'(bus.done), 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
